boot_sequencer: RTL and testbench

- Host-side controller that sequences per-tile boot managers over the service network.
- On a start pulse it walks the selected tiles one at a time. For each tile it:
  - issues one BOOT_COMMAND service message per selected thread (PC plus thread id);
  - then issues one ENABLE_THREAD message carrying the thread mask.
- Sits between the host interface and the service-message injection port of the host tile.

---
 rtl/boot_seq_pkg.sv | 40 ++++
 rtl/boot_seq_priority_sel.sv | 16 +
 rtl/boot_sequencer.sv | 93 +++++++++
 tb/tb_boot_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/boot_seq_pkg.sv
// boot_seq_pkg: shared service-message types, FSM states and message builders for boot_sequencer.
package boot_seq_pkg;
  localparam int TILE_COUNT = 4;
  localparam int THREAD_NUMB = 4;
  localparam int ADDRESS_WIDTH = 32;
  localparam int TILE_IDX_W = TILE_COUNT > 1 ? $clog2(TILE_COUNT) : 1;
  localparam int THREAD_ID_W = THREAD_NUMB > 1 ? $clog2(THREAD_NUMB) : 1;
  typedef logic [ADDRESS_WIDTH-1:0] address_t;
  typedef logic [TILE_COUNT-1:0] tile_mask_t;
  typedef logic [THREAD_NUMB-1:0] thread_mask_t;
  typedef logic [THREAD_ID_W-1:0] thread_id_t;
  typedef enum logic [2:0] {IDLE, SCAN, BOOT, ENABLE, FINISH} boot_seq_state_t;
  typedef enum logic [1:0] {SVC_NONE, HOST, DEVICE} service_type_t;
  typedef enum logic [1:0] {HM_NONE, BOOT_COMMAND, ENABLE_THREAD} host_message_code_t;
  typedef struct packed {
    host_message_code_t message;
    logic               hi_job_valid;
    address_t           hi_job_pc;
    thread_id_t         hi_job_thread_id;
    thread_mask_t       hi_thread_en;
  } host_message_t;
  typedef struct packed {
    service_type_t message_type;
    host_message_t data;
  } service_message_t;
  function automatic service_message_t boot_msg(address_t pc, thread_id_t tid);
    boot_msg = '0;
    boot_msg.message_type = HOST;
    boot_msg.data.message = BOOT_COMMAND;
    boot_msg.data.hi_job_valid = 1'b1;
    boot_msg.data.hi_job_pc = pc;
    boot_msg.data.hi_job_thread_id = tid;
  endfunction
  function automatic service_message_t enable_msg(thread_mask_t mask);
    enable_msg = '0;
    enable_msg.message_type = HOST;
    enable_msg.data.message = ENABLE_THREAD;
    enable_msg.data.hi_thread_en = mask;
  endfunction
endpackage

// File: rtl/boot_seq_priority_sel.sv
// boot_seq_priority_sel: lowest-set-bit finder returning a one-hot and its index.
module boot_seq_priority_sel #(
  parameter int W = 4,
  localparam int IW = W > 1 ? $clog2(W) : 1
) (
  input  logic [W-1:0]  mask,
  output logic [W-1:0]  onehot,
  output logic [IW-1:0] idx
);
  assign onehot = mask & (~mask + W'(1));
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--)
      if (mask[i]) idx = IW'(i);
  end
endmodule

// File: rtl/boot_sequencer.sv
// boot_sequencer: walks selected tiles, sending BOOT_COMMAND per thread then ENABLE_THREAD per tile.
// Define BOOT_SEQ_BROADCAST_EN to multicast one message set to all selected tiles.
module boot_sequencer
  import boot_seq_pkg::*;
#(
  parameter address_t PC_STRIDE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  address_t         base_pc,
  input  tile_mask_t       tile_sel,
  input  thread_mask_t     thread_sel,
  input  logic             network_available,
  output service_message_t message_out,
  output logic             message_out_valid,
  output tile_mask_t       destination_valid,
  output logic             busy,
  output logic             done
);
  boot_seq_state_t state;
  address_t base_q;
  thread_mask_t thread_q, thr_rem, thr_oh;
  tile_mask_t tile_pend, tile_oh, tile_left, dest_q;
  logic [TILE_IDX_W-1:0] tile_idx;
  thread_id_t thr_idx;
  service_message_t next_boot;
  logic sent;
  boot_seq_priority_sel #(.W(TILE_COUNT)) u_tile_sel (.mask(tile_pend), .onehot(tile_oh), .idx(tile_idx));
  boot_seq_priority_sel #(.W(THREAD_NUMB)) u_thread_sel (.mask(thr_rem), .onehot(thr_oh), .idx(thr_idx));
  assign next_boot = boot_msg(base_q + address_t'(thr_idx) * PC_STRIDE, thr_idx);
  assign tile_left = tile_pend & ~(tile_mask_t'(1) << tile_idx);
  assign sent = (state == BOOT || state == ENABLE) && network_available;
  assign message_out_valid = sent;
  assign destination_valid = sent ? dest_q : '0;
  // thr_rem holds threads whose BOOT_COMMAND has not yet been loaded into message_out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      base_q <= '0;
      thread_q <= '0;
      thr_rem <= '0;
      tile_pend <= '0;
      dest_q <= '0;
      message_out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !done) begin
          base_q <= base_pc;
          thread_q <= thread_sel;
          thr_rem <= thread_sel;
          tile_pend <= tile_sel;
          busy <= 1'b1;
          state <= (tile_sel == '0 || thread_sel == '0) ? FINISH : SCAN;
        end
        SCAN: begin
`ifdef BOOT_SEQ_BROADCAST_EN
          dest_q <= tile_pend;
`else
          dest_q <= tile_oh;
`endif
          message_out <= next_boot;
          thr_rem <= thr_rem & ~thr_oh;
          state <= BOOT;
        end
        BOOT: if (network_available) begin
          message_out <= thr_rem != '0 ? next_boot : enable_msg(thread_q);
          thr_rem <= thr_rem & ~thr_oh;
          state <= thr_rem != '0 ? BOOT : ENABLE;
        end
        ENABLE: if (network_available) begin
          thr_rem <= thread_q;
`ifdef BOOT_SEQ_BROADCAST_EN
          tile_pend <= '0;
          state <= FINISH;
`else
          tile_pend <= tile_left;
          state <= tile_left != '0 ? SCAN : FINISH;
`endif
        end
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_boot_sequencer.sv
// tb_boot_sequencer: directed tests against a queue model of the expected message stream.
module tb_boot_sequencer;
  import boot_seq_pkg::*;
  localparam address_t STRIDE = 32'h100;
  logic clk = 0, reset = 1, start = 0, network_available = 1;
  address_t base_pc = '0;
  tile_mask_t tile_sel = '0;
  thread_mask_t thread_sel = '0;
  service_message_t message_out;
  logic message_out_valid, busy, done;
  tile_mask_t destination_valid;
  typedef struct packed {
    tile_mask_t dest;
    service_message_t msg;
  } exp_t;
  exp_t exp_q[$];
  int compared = 0, mismatched = 0, sent_cnt = 0;

  boot_sequencer #(.PC_STRIDE(STRIDE)) dut (
    .clk(clk), .reset(reset), .start(start), .base_pc(base_pc), .tile_sel(tile_sel),
    .thread_sel(thread_sel), .network_available(network_available), .message_out(message_out),
    .message_out_valid(message_out_valid), .destination_valid(destination_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  function automatic service_message_t mk(bit en, address_t pc, int tid, thread_mask_t thr);
    service_message_t m = '0;
    m.message_type = HOST;
    if (en) begin
      m.data.message = ENABLE_THREAD;
      m.data.hi_thread_en = thr;
    end else begin
      m.data.message = BOOT_COMMAND;
      m.data.hi_job_valid = 1'b1;
      m.data.hi_job_pc = pc;
      m.data.hi_job_thread_id = thread_id_t'(tid);
    end
    return m;
  endfunction

  task automatic model(tile_mask_t tiles, thread_mask_t thr, address_t base);
    if (tiles == '0 || thr == '0) return;
    for (int t = 0; t < TILE_COUNT; t++) begin
      if (tiles[t]) begin
        tile_mask_t d;
`ifdef BOOT_SEQ_BROADCAST_EN
        d = tiles;
`else
        d = '0;
        d[t] = 1'b1;
`endif
        for (int h = 0; h < THREAD_NUMB; h++)
          if (thr[h]) exp_q.push_back('{d, mk(0, base + address_t'(h) * STRIDE, h, '0)});
        exp_q.push_back('{d, mk(1, '0, 0, thr)});
`ifdef BOOT_SEQ_BROADCAST_EN
        break;
`endif
      end
    end
  endtask

  function automatic int exp_cycles(tile_mask_t tiles, thread_mask_t thr);
    int groups;
    if (tiles == '0 || thr == '0) return 2;
`ifdef BOOT_SEQ_BROADCAST_EN
    groups = 1;
`else
    groups = $countones(tiles);
`endif
    return 2 + groups * ($countones(thr) + 2);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (message_out_valid) begin
        sent_cnt++;
        check("valid_needs_avail", network_available, 1);
        if (exp_q.size() == 0) check("unexpected_msg", message_out_valid, 0);
        else check("msg", {destination_valid, message_out}, exp_q.pop_front());
      end else check("dest_idle_zero", destination_valid, 0);
    end
  end

  task automatic run(tile_mask_t tiles, thread_mask_t thr, address_t base, bit toggle, bit chk_cyc,
                     tile_mask_t inject);
    bit pat[4] = '{1, 0, 0, 1};
    int n, want;
    model(tiles, thr, base);
    want = exp_cycles(tiles, thr);
    @(posedge clk); #1;
    tile_sel = tiles; thread_sel = thr; base_pc = base; start = 1;
    @(posedge clk); #1;
    start = 0;
    n = 1;
    if (tiles == '0 || thr == '0) check("busy_one_cycle", busy, 1);
    while (!done && n < 2000) begin
      if (toggle) network_available = pat[n % 4];
      if (inject != '0) begin
        start = (n == 3);
        if (n == 3) begin tile_sel = inject; base_pc = 32'hDEAD_0000; end
      end
      @(posedge clk); #1;
      n++;
    end
    start = 0;
    network_available = 1;
    check("done_seen", done, 1);
    check("busy_low_at_done", busy, 0);
    if (chk_cyc) check("latency", n, want);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int k;
    // pin the model with hand-computed values
    model(4'b0101, 4'b0011, 32'h400);
    check("model_pc1", exp_q[1].msg.data.hi_job_pc, 32'h500);
    check("model_tid1", exp_q[1].msg.data.hi_job_thread_id, 1);
    check("model_en", exp_q[2].msg.data.hi_thread_en, 4'b0011);
`ifdef BOOT_SEQ_BROADCAST_EN
    check("model_size", exp_q.size(), 3);
    check("model_cycles", exp_cycles(4'b0101, 4'b0011), 6);
`else
    check("model_size", exp_q.size(), 6);
    check("model_dest3", exp_q[3].dest, 4'b0100);
    check("model_cycles", exp_cycles(4'b0101, 4'b0011), 10);
`endif
    exp_q.delete();
    model(4'b1110, 4'b1000, 32'h1000);
    check("model_bc_pc", exp_q[0].msg.data.hi_job_pc, 32'h1300);
`ifdef BOOT_SEQ_BROADCAST_EN
    check("model_bc_dest", exp_q[0].dest, 4'b1110);
`else
    check("model_bc_dest", exp_q[0].dest, 4'b0010);
`endif
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", message_out_valid, 0);
    check("rst_msg", message_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 0;
    // unicast boot, then start in the done cycle must be ignored
    run(4'b0101, 4'b0011, 32'h400, 0, 1, '0);
    start = 1; tile_sel = 4'b1111; thread_sel = 4'b1111;
    @(posedge clk); #1;
    start = 0;
    check("start_at_done_ignored", busy, 0);
    // backpressure
    sent_cnt = 0;
    run(4'b0101, 4'b0011, 32'h400, 1, 0, '0);
`ifdef BOOT_SEQ_BROADCAST_EN
    check("bp_count", sent_cnt, 3);
`else
    check("bp_count", sent_cnt, 6);
`endif
    // empty masks
    sent_cnt = 0;
    run(4'b0101, 4'b0000, 32'h400, 0, 1, '0);
    run(4'b0000, 4'b0011, 32'h400, 0, 1, '0);
    check("empty_no_msgs", sent_cnt, 0);
    // start while busy
    run(4'b0011, 4'b0101, 32'h2000, 0, 1, 4'b1000);
    // broadcast stimulus
    run(4'b1110, 4'b1000, 32'h1000, 0, 1, '0);
    // reset mid-sequence during tile 2
    model(4'b0101, 4'b0011, 32'h400);
    @(posedge clk); #1;
    tile_sel = 4'b0101; thread_sel = 4'b0011; base_pc = 32'h400; start = 1;
    @(posedge clk); #1;
    start = 0;
    k = 0;
    while (!destination_valid[2] && k < 100) begin @(posedge clk); #1; k++; end
    check("wait_tile2", destination_valid[2], 1);
    #1 reset = 1;
    #1;
    check("async_rst_valid", message_out_valid, 0);
    check("async_rst_dest", destination_valid, 0);
    check("async_rst_msg", message_out, 0);
    check("async_rst_busy", busy, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 0;
    run(4'b0101, 4'b0011, 32'h400, 0, 1, '0);
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
